sha256_arbiter: RTL and testbench
=================================

SHA256_ARBITER -- requirements
Module: sha256_arbiter

Interface
REQ-001 Parameters SHALL be: NUM_REQ, default 4, number of requesters (2..8); START_CYCLES, default 2, cycles core_start_o is held; TIMEOUT, default 1024, maximum cycles to wait for core_valid_i.
REQ-002 Widths SHALL derive from sha256_pkg::BLOCK_SIZE (256): message = 2*BLOCK_SIZE bits, digest = BLOCK_SIZE bits.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk_i, in, 1, single clock, all logic on rising edge.
- rst_i, in, 1, asynchronous active-high reset.
- req_i, in, NUM_REQ, per-requester request level.
- msg_i, in, NUM_REQ*2*BLOCK_SIZE, padded block for requester k at slice k.
- gnt_o, out, NUM_REQ, one-hot single-cycle accept pulse.
- done_o, out, NUM_REQ, one-hot single-cycle completion pulse.
- err_o, out, 1, qualifies done_o: 1 = timeout.
- md_o, out, BLOCK_SIZE, digest for the requester pulsed on done_o.
- busy_o, out, 1, high in any state other than IDLE.
- core_start_o, out, 1, drives sha256_core start_i.
- core_msg_o, out, 2*BLOCK_SIZE, drives sha256_core msg_i.
- core_md_i, in, BLOCK_SIZE, from sha256_core md_o.
- core_valid_i, in, 1, from sha256_core valid_o.
REQ-004 Clock and reset SHALL be one clock, clk_i, and an asynchronous active-high reset, rst_i.

Function
REQ-005 The FSM SHALL have states IDLE, START, WAIT and RESP, all encoded and registered.
REQ-006 In IDLE with any req_i bit high, the block SHALL select the winner round-robin, searching from index ptr upward with wrap-around.
- On the same edge: register gnt_o[winner]=1, latch msg_i slice into core_msg_o, record owner, set ptr=(winner+1) mod NUM_REQ, go to START.
REQ-007 gnt_o SHALL be high for exactly the first START cycle.
- A requester SHALL hold req_i and msg_i stable until it sees its gnt_o.
- A req_i that drops before the grant edge SHALL NOT be granted.
REQ-008 In START, core_start_o SHALL be 1 for exactly START_CYCLES consecutive cycles, then the FSM SHALL go to WAIT.
REQ-009 core_msg_o SHALL stay constant from grant until the next grant.
REQ-010 WAIT SHALL arm only after core_valid_i is sampled 0 at least once, so stale valid from a previous operation is ignored.
- Once armed, the first sampled core_valid_i=1 SHALL latch core_md_i into md_o and move to RESP.
REQ-011 A WAIT cycle counter SHALL run from entry to WAIT.
- If it reaches TIMEOUT without capture, the FSM SHALL go to RESP with err_o=1 and md_o=0.
REQ-012 RESP SHALL last exactly one cycle: done_o[owner]=1, err_o per REQ-011, then return to IDLE.
REQ-013 md_o SHALL hold its value until the next RESP.
REQ-014 err_o SHALL be 0 whenever done_o is 0.
REQ-015 Requests arriving in START, WAIT or RESP SHALL wait and SHALL be arbitrated in the next IDLE cycle.
- At least one IDLE cycle occurs between operations.
- Grant-to-done latency = START_CYCLES + WAIT cycles + 1.
REQ-016 When only one requester is active, it SHALL be granted every operation with no extra idle cycles beyond REQ-015.
REQ-017 When all requesters are active continuously, grants SHALL rotate 0,1,...,NUM_REQ-1,0, with no requester granted twice before every other active requester is granted once.
REQ-018 The block SHALL NOT reset or otherwise control sha256_core beyond core_start_o and core_msg_o.

Reset
REQ-019 While rst_i=1, asynchronously and independent of clk_i:
- state = IDLE, ptr = 0, counters = 0.
- gnt_o, done_o, err_o, busy_o and core_start_o = 0.
- md_o = 0 and core_msg_o = 0.
REQ-020 Reset asserted mid-operation SHALL abort the operation with no done_o pulse.
- After release, the first IDLE cycle SHALL arbitrate normally from ptr=0.

Verification
REQ-021 Single request: req_i=0001, slice 0 = "abc" padded block (61626380_..._00000018) -> gnt_o=0001 one cycle, core_start_o high 2 cycles, done_o=0001, err_o=0, md_o=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
REQ-022 Contention: req_i=1111 held, slices = empty/"abc"/empty/"abc" -> grant order 0,1,2,3,0, digests e3b0c442...b855 / ba7816bf...15ad alternating on matching done_o.
REQ-023 Fairness: after a grant to 2, assert req_i=0101 -> next grant 0, then 2.
REQ-024 Timeout: core model with core_valid_i stuck 0, TIMEOUT=16 -> done_o[owner] 16 cycles after WAIT entry, err_o=1, md_o=0; next request proceeds normally.
REQ-025 Stale valid: core_valid_i held 1 across a new START -> no capture until core_valid_i is observed 0 then 1; md_o = new digest.
REQ-026 Reset mid-WAIT: assert rst_i -> all outputs 0 immediately, no done_o pulse; after release, req_i=0010 -> gnt_o=0010 on the first edge out of IDLE.

Source files
------------

// File: rtl/sha256_arbiter.sv
// Round-robin front end that shares one sha256_core among NUM_REQ requesters.
// Each operation grants one padded block, runs the core, and returns its digest or a timeout error.
package sha256_pkg;
  localparam int BLOCK_SIZE = 256;
endpackage

module sha256_arbiter
  import sha256_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT      = 1024
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_REQ-1:0]              req_i,
  input  logic [NUM_REQ*2*BLOCK_SIZE-1:0] msg_i,
  output logic [NUM_REQ-1:0]              gnt_o,
  output logic [NUM_REQ-1:0]              done_o,
  output logic                            err_o,
  output logic [BLOCK_SIZE-1:0]           md_o,
  output logic                            busy_o,
  output logic                            core_start_o,
  output logic [2*BLOCK_SIZE-1:0]         core_msg_o,
  input  logic [BLOCK_SIZE-1:0]           core_md_i,
  input  logic                            core_valid_i
);

  localparam int MSG_W = 2 * BLOCK_SIZE;
  localparam int MD_W  = BLOCK_SIZE;
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW    = IDX_W + 1;
  localparam int SC_W  = $clog2(START_CYCLES + 1);
  localparam int WC_W  = $clog2(TIMEOUT + 1);
  localparam logic [SC_W-1:0]  START_LAST = SC_W'(START_CYCLES - 1);
  localparam logic [WC_W-1:0]  WAIT_LAST  = WC_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t             state_r, state_s;
  logic [IDX_W-1:0]   ptr_r, ptr_s;
  logic [IDX_W-1:0]   owner_r, owner_s;
  logic [SC_W-1:0]    start_cnt_r, start_cnt_s;
  logic [WC_W-1:0]    wait_cnt_r, wait_cnt_s;
  logic               armed_r, armed_s;
  logic [NUM_REQ-1:0] gnt_r, gnt_s;
  logic [NUM_REQ-1:0] done_r, done_s;
  logic               err_r, err_s;
  logic [MD_W-1:0]    md_r, md_s;
  logic               busy_r, busy_s;
  logic               core_start_r, core_start_s;
  logic [MSG_W-1:0]   core_msg_r, core_msg_s;

  logic [PW-1:0]      pick_s;
  logic               found_s;
  logic [IDX_W-1:0]   winner_s;
  logic [IDX_W-1:0]   next_ptr_s;
  logic [MSG_W-1:0]   win_msg_s;
  logic               capture_s;
  logic               timeout_s;
  logic               start_last_s;

  // Returns {found, index} of the first request at or above ptr, wrapping around.
  function automatic logic [PW-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                            input logic [IDX_W-1:0]   ptr);
    logic [PW-1:0] res;
    logic [PW-1:0] idx;
    res = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = {1'b0, ptr} + PW'(i);
      if (idx >= PW'(NUM_REQ)) begin
        idx = idx - PW'(NUM_REQ);
      end else begin
        idx = idx;
      end
      if (req[idx[IDX_W-1:0]]) begin
        res = {1'b1, idx[IDX_W-1:0]};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign pick_s       = rr_pick(req_i, ptr_r);
  assign found_s      = pick_s[IDX_W];
  assign winner_s     = pick_s[IDX_W-1:0];
  assign next_ptr_s   = (winner_s == IDX_LAST) ? '0 : winner_s + IDX_W'(1);
  assign start_last_s = (start_cnt_r == START_LAST);
  // Valid is only believed once it has been seen low during this WAIT.
  assign capture_s    = (state_r == WAIT) && armed_r && core_valid_i;
  assign timeout_s    = (state_r == WAIT) && !capture_s && (wait_cnt_r == WAIT_LAST);

  // Select the winning requester's message slice.
  always_comb begin
    win_msg_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (winner_s == IDX_W'(k)) begin
        win_msg_s = msg_i[k*MSG_W +: MSG_W];
      end else begin
        win_msg_s = win_msg_s;
      end
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (found_s) state_s = START;
        else         state_s = IDLE;
      end
      START: begin
        if (start_last_s) state_s = WAIT;
        else              state_s = START;
      end
      WAIT: begin
        if (capture_s || timeout_s) state_s = RESP;
        else                        state_s = WAIT;
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Next values for the registered outputs and bookkeeping.
  always_comb begin
    gnt_s        = '0;
    done_s       = '0;
    err_s        = 1'b0;
    core_start_s = 1'b0;
    md_s         = md_r;
    core_msg_s   = core_msg_r;
    ptr_s        = ptr_r;
    owner_s      = owner_r;
    start_cnt_s  = start_cnt_r;
    wait_cnt_s   = wait_cnt_r;
    armed_s      = armed_r;
    busy_s       = (state_s != IDLE);
    case (state_r)
      IDLE: begin
        if (found_s) begin
          gnt_s[winner_s] = 1'b1;
          core_msg_s      = win_msg_s;
          owner_s         = winner_s;
          ptr_s           = next_ptr_s;
          core_start_s    = 1'b1;
          start_cnt_s     = '0;
        end else begin
          gnt_s = '0;
        end
      end
      START: begin
        if (start_last_s) begin
          start_cnt_s = '0;
          wait_cnt_s  = '0;
          armed_s     = 1'b0;
        end else begin
          core_start_s = 1'b1;
          start_cnt_s  = start_cnt_r + SC_W'(1);
        end
      end
      WAIT: begin
        if (capture_s) begin
          md_s             = core_md_i;
          done_s[owner_r]  = 1'b1;
        end else if (timeout_s) begin
          md_s             = '0;
          err_s            = 1'b1;
          done_s[owner_r]  = 1'b1;
        end else begin
          wait_cnt_s = wait_cnt_r + WC_W'(1);
          armed_s    = armed_r | ~core_valid_i;
        end
      end
      RESP: begin
        armed_s = 1'b0;
      end
      default: begin
        armed_s = 1'b0;
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_r        <= '0;
      owner_r      <= '0;
      start_cnt_r  <= '0;
      wait_cnt_r   <= '0;
      armed_r      <= 1'b0;
      gnt_r        <= '0;
      done_r       <= '0;
      err_r        <= 1'b0;
      md_r         <= '0;
      busy_r       <= 1'b0;
      core_start_r <= 1'b0;
      core_msg_r   <= '0;
    end else begin
      ptr_r        <= ptr_s;
      owner_r      <= owner_s;
      start_cnt_r  <= start_cnt_s;
      wait_cnt_r   <= wait_cnt_s;
      armed_r      <= armed_s;
      gnt_r        <= gnt_s;
      done_r       <= done_s;
      err_r        <= err_s;
      md_r         <= md_s;
      busy_r       <= busy_s;
      core_start_r <= core_start_s;
      core_msg_r   <= core_msg_s;
    end
  end

  assign gnt_o        = gnt_r;
  assign done_o       = done_r;
  assign err_o        = err_r;
  assign md_o         = md_r;
  assign busy_o       = busy_r;
  assign core_start_o = core_start_r;
  assign core_msg_o   = core_msg_r;

endmodule

// File: tb/tb_sha256_arbiter.sv
// Self-checking bench for sha256_arbiter with a behavioural sha256_core stand-in.
// Table-driven arbitration vectors plus hand-written timeout, stale-valid and reset sequences.
module tb_sha256_arbiter;

  localparam int NR = 4;

  localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
  localparam logic [255:0] ABC_DIG   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_DIG = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  logic            clk = 1'b0;
  logic            rst_i;
  logic [NR-1:0]   req_i;
  logic [NR*512-1:0] msg_i;
  logic [NR-1:0]   gnt_o;
  logic [NR-1:0]   done_o;
  logic            err_o;
  logic [255:0]    md_o;
  logic            busy_o;
  logic            core_start_o;
  logic [511:0]    core_msg_o;
  logic [255:0]    core_md_i;
  logic            core_valid_i;

  sha256_arbiter #(.NUM_REQ(NR), .START_CYCLES(2), .TIMEOUT(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .msg_i(msg_i),
    .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o), .md_o(md_o), .busy_o(busy_o),
    .core_start_o(core_start_o), .core_msg_o(core_msg_o),
    .core_md_i(core_md_i), .core_valid_i(core_valid_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 0 = auto core model, 1 = valid stuck low, 2 = driven by hand
  int core_mode = 0;
  int core_cnt  = 0;
  always @(negedge clk) begin
    if (core_mode == 0) begin
      if (core_start_o) begin
        core_valid_i = 1'b0;
        core_cnt     = 3;
      end else if (core_cnt > 1) begin
        core_cnt = core_cnt - 1;
      end else if (core_cnt == 1) begin
        core_valid_i = 1'b1;
        core_md_i    = (core_msg_o == ABC_BLK) ? ABC_DIG :
                       (core_msg_o == EMPTY_BLK) ? EMPTY_DIG : {256{1'b1}};
        core_cnt     = 0;
      end
    end else if (core_mode == 1) begin
      core_valid_i = 1'b0;
    end
  end

  typedef struct { int owner; logic err; logic [255:0] md; } exp_t;
  exp_t sb[$];

  typedef struct { logic [3:0] req; logic [3:0] sel; int nops; logic [23:0] ord; } vec_t;
  vec_t vecs [6];

  int n_checks = 0;
  int n_err    = 0;
  logic [3:0]   sel;
  logic [255:0] last_md;
  logic [511:0] last_msg;

  function automatic logic [511:0] block_of(input logic s);
    return s ? ABC_BLK : EMPTY_BLK;
  endfunction

  function automatic logic [255:0] digest_of(input logic s);
    return s ? ABC_DIG : EMPTY_DIG;
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_msgs();
    for (int k = 0; k < NR; k++) msg_i[k*512 +: 512] = block_of(sel[k]);
  endtask

  // Waits for a grant, checks it and the start pulse, and queues the expected response.
  task automatic do_grant(input int exp_idx, input logic exp_err, input logic [255:0] exp_md,
                          output int gcyc);
    int n;
    logic [3:0] e_gnt;
    exp_t e;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt_o == '0 && n < 40);
    gcyc  = cyc;
    e_gnt = 4'b0001 << exp_idx;
    chk("gnt_onehot", 512'(gnt_o), 512'(e_gnt));
    last_msg = block_of(sel[exp_idx]);
    chk("core_msg_latch", core_msg_o, last_msg);
    chk("start_c1", 512'(core_start_o), 512'(1'b1));
    chk("busy_op", 512'(busy_o), 512'(1'b1));
    e.owner = exp_idx;
    e.err   = exp_err;
    e.md    = exp_md;
    sb.push_back(e);
    @(negedge clk);
    chk("gnt_one_cycle", 512'(gnt_o), 512'(0));
    chk("start_c2", 512'(core_start_o), 512'(1'b1));
    @(negedge clk);
    chk("start_end", 512'(core_start_o), 512'(1'b0));
  endtask

  // Waits for done_o and compares against the oldest queued expectation.
  task automatic do_done(output int dcyc);
    int n;
    exp_t e;
    logic [3:0] e_done;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done_o == '0 && n < 40);
    dcyc = cyc;
    if (sb.size() == 0) begin
      n_checks++;
      n_err++;
      $display("FAIL sb_underflow: got done %0h expected no response", done_o);
    end else begin
      e = sb.pop_front();
      e_done = 4'b0001 << e.owner;
      chk("done_onehot", 512'(done_o), 512'(e_done));
      chk("err", 512'(err_o), 512'(e.err));
      chk("md", 512'(md_o), 512'(e.md));
      last_md = e.md;
    end
  endtask

  task automatic idle_check();
    @(negedge clk);
    chk("done_one_cycle", 512'(done_o), 512'(0));
    chk("err_low_idle", 512'(err_o), 512'(0));
    chk("md_hold", 512'(md_o), 512'(last_md));
    chk("core_msg_hold", core_msg_o, last_msg);
    chk("busy_idle", 512'(busy_o), 512'(0));
  endtask

  initial begin
    int gcyc, dcyc, rel_cyc, exp_idx, stale_hit;
    logic [23:0] ord_v;

    rst_i = 1'b1; req_i = '0; msg_i = '0; core_valid_i = 1'b0; core_md_i = '0;
    last_md = '0; last_msg = '0; sel = '0; gcyc = 0; dcyc = 0;

    repeat (2) @(negedge clk);
    chk("rst_gnt", 512'(gnt_o), 512'(0));
    chk("rst_done", 512'(done_o), 512'(0));
    chk("rst_err", 512'(err_o), 512'(0));
    chk("rst_busy", 512'(busy_o), 512'(0));
    chk("rst_start", 512'(core_start_o), 512'(0));
    chk("rst_md", 512'(md_o), 512'(0));
    chk("rst_core_msg", core_msg_o, 512'(0));
    rst_i = 1'b0;

    vecs[0] = '{req: 4'b1111, sel: 4'b1010, nops: 5, ord: 24'h003210};
    vecs[1] = '{req: 4'b0001, sel: 4'b0001, nops: 2, ord: 24'h000000};
    vecs[2] = '{req: 4'b0100, sel: 4'b0000, nops: 1, ord: 24'h000002};
    vecs[3] = '{req: 4'b0101, sel: 4'b0100, nops: 2, ord: 24'h000020};
    vecs[4] = '{req: 4'b1010, sel: 4'b1000, nops: 3, ord: 24'h000313};
    vecs[5] = '{req: 4'b0110, sel: 4'b0010, nops: 3, ord: 24'h000121};

    for (int v = 0; v < 6; v++) begin
      sel = vecs[v].sel;
      set_msgs();
      req_i = vecs[v].req;
      for (int k = 0; k < vecs[v].nops; k++) begin
        ord_v   = vecs[v].ord >> (4 * k);
        exp_idx = int'(ord_v[3:0]);
        do_grant(exp_idx, 1'b0, digest_of(sel[exp_idx]), gcyc);
        if (k > 0) chk_int("rr_gap", gcyc - dcyc, 2);
        do_done(dcyc);
        if (k == vecs[v].nops - 1) req_i = '0;
        idle_check();
      end
      @(negedge clk);
      chk("no_grant_after_drop", 512'(gnt_o), 512'(0));
    end

    // Timeout: core never answers
    core_mode = 1;
    sel = 4'b0000; set_msgs(); req_i = 4'b1000;
    do_grant(3, 1'b1, 256'h0, gcyc);
    req_i = '0;
    do_done(dcyc);
    chk_int("timeout_latency", dcyc - gcyc, 18);
    idle_check();

    // Next request after a timeout proceeds normally
    core_mode = 0;
    sel = 4'b0001; set_msgs(); req_i = 4'b0001;
    do_grant(0, 1'b0, ABC_DIG, gcyc);
    req_i = '0;
    do_done(dcyc);
    idle_check();

    // Stale valid: core still shows the previous digest with valid high
    core_mode = 2;
    sel = 4'b0000; set_msgs(); req_i = 4'b0010;
    do_grant(1, 1'b0, EMPTY_DIG, gcyc);
    req_i = '0;
    stale_hit = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done_o != '0) stale_hit = 1;
    end
    chk_int("stale_ignored", stale_hit, 0);
    chk("md_hold_stale", 512'(md_o), 512'(ABC_DIG));
    core_valid_i = 1'b0;
    @(negedge clk);
    core_valid_i = 1'b1;
    core_md_i    = EMPTY_DIG;
    do_done(dcyc);
    idle_check();

    // Reset in the middle of WAIT
    core_mode = 1;
    sel = 4'b0000; set_msgs(); req_i = 4'b0100;
    do_grant(2, 1'b0, EMPTY_DIG, gcyc);
    req_i = '0;
    repeat (3) @(negedge clk);
    sb.delete();
    #2 rst_i = 1'b1;
    #1;
    chk("arst_gnt", 512'(gnt_o), 512'(0));
    chk("arst_done", 512'(done_o), 512'(0));
    chk("arst_err", 512'(err_o), 512'(0));
    chk("arst_busy", 512'(busy_o), 512'(0));
    chk("arst_start", 512'(core_start_o), 512'(0));
    chk("arst_md", 512'(md_o), 512'(0));
    chk("arst_core_msg", core_msg_o, 512'(0));
    stale_hit = 0;
    repeat (3) begin
      @(negedge clk);
      if (done_o != '0) stale_hit = 1;
    end
    chk_int("no_done_in_reset", stale_hit, 0);
    rst_i = 1'b0;
    core_mode = 0;
    sel = 4'b0010; set_msgs(); req_i = 4'b0010;
    rel_cyc = cyc;
    do_grant(1, 1'b0, ABC_DIG, gcyc);
    chk_int("grant_after_reset", gcyc - rel_cyc, 1);
    req_i = '0;
    do_done(dcyc);
    idle_check();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
